p1_mem_write: RTL and testbench

// - Write-side address generator for the pooling-1 output memory; pairs with the conv2 read counter.
// - Accepts the pooled pixel stream in raster order (row-major, one 12x12 image after another).
// - Produces a registered write strobe, address and data into the single-port P1 buffer.
// - Raises done once all NUM_IMG planes are stored, releasing conv2 reads.

---
 rtl/p1_mem_write_if.sv | 26 ++
 rtl/p1_mem_write.sv | 106 ++++++++++
 tb/tb_p1_mem_write.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/p1_mem_write_if.sv
// Pooled-pixel stream in, P1 buffer write port out. The master side drives the
// stream; the slave side (p1_mem_write) returns in_ready and the memory write.
interface p1_mem_write_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 16
);
   logic              enable;
   logic              in_valid;
   logic [DATA_W-1:0] in_data;
   logic              in_ready;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic [1:0]        img_idx;
   logic              done;

   modport master (
      output enable, in_valid, in_data,
      input  in_ready, wr_en, wr_addr, wr_data, img_idx, done
   );

   modport slave (
      input  enable, in_valid, in_data,
      output in_ready, wr_en, wr_addr, wr_data, img_idx, done
   );
endinterface

// File: rtl/p1_mem_write.sv
// Write-side address generator for the pooling-1 buffer: raster-order stream in,
// registered write out, done after NUM_IMG planes. Define P1W_RELU_EN to clamp negatives to 0.
module p1_mem_write #(
   parameter int IMG_W   = 12,
   parameter int IMG_H   = 12,
   parameter int NUM_IMG = 3,
   parameter int ADDR_W  = 8,
   parameter int DATA_W  = 16
) (
   input logic          clk,
   input logic          reset,
   p1_mem_write_if.slave bus
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] row, col;
   logic [1:0]        plane;
   logic              accept;
   logic              col_end, row_end, img_end, last_pix;
   logic [DATA_W-1:0] cap_data;

   logic              wr_en_q;
   logic [ADDR_W-1:0] wr_addr_q;
   logic [DATA_W-1:0] wr_data_q;
   logic [1:0]        img_idx_q;
   logic              done_q;

   assign bus.in_ready = bus.enable && (state != DONE);
   assign accept       = bus.in_valid && bus.in_ready;

   assign col_end  = (col == ADDR_W'(IMG_W - 1));
   assign row_end  = (row == ADDR_W'(IMG_H - 1));
   assign img_end  = col_end && row_end;
   assign last_pix = img_end && (plane == 2'(NUM_IMG - 1));

`ifdef P1W_RELU_EN
   assign cap_data = bus.in_data[DATA_W-1] ? '0 : bus.in_data;
`else
   assign cap_data = bus.in_data;
`endif

   always_ff @(posedge clk) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (accept) state_nxt = last_pix ? DONE : RUN;
         RUN:  if (accept && last_pix) state_nxt = DONE;
         DONE: state_nxt = DONE;
         default: state_nxt = IDLE;
      endcase
   end

   // Next-accept position; row/col wrap keeps the address modulo IMG_W*IMG_H.
   always_ff @(posedge clk) begin
      if (!reset) begin
         row   <= '0;
         col   <= '0;
         plane <= '0;
      end else if (accept) begin
         if (col_end) begin
            col <= '0;
            if (row_end) begin
               row   <= '0;
               plane <= (plane == 2'(NUM_IMG - 1)) ? 2'd0 : plane + 2'd1;
            end else begin
               row <= row + 1'b1;
            end
         end else begin
            col <= col + 1'b1;
         end
      end
   end

   // Write port: strobe follows each accept by one cycle; addr/data/plane hold otherwise.
   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         img_idx_q <= '0;
         done_q    <= 1'b0;
      end else begin
         wr_en_q <= accept;
         if (accept) begin
            wr_addr_q <= row * ADDR_W'(IMG_W) + col;
            wr_data_q <= cap_data;
            img_idx_q <= plane;
         end
         // DONE is entered on the last accept, so this lands one cycle after the last write.
         if (state == DONE) done_q <= 1'b1;
      end
   end

   assign bus.wr_en   = wr_en_q;
   assign bus.wr_addr = wr_addr_q;
   assign bus.wr_data = wr_data_q;
   assign bus.img_idx = img_idx_q;
   assign bus.done    = done_q;

endmodule

// File: tb/tb_p1_mem_write.sv
// Directed bench for p1_mem_write: cycle-by-cycle reference of the write port
// against gapless, gapped, post-done, mid-frame reset and sign-boundary stimulus.
module tb_p1_mem_write;
   localparam int NPIX = 144;
   localparam int NTOT = 432;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   p1_mem_write_if #(.ADDR_W(8), .DATA_W(16)) bus ();

   p1_mem_write dut (.clk(clk), .reset(reset), .bus(bus));

   int n_vec = 0;
   int n_err = 0;

   // reference state
   int          m_cnt;
   logic        m_done;
   logic        e_we, e_done;
   logic [7:0]  e_addr;
   logic [15:0] e_data;
   logic [1:0]  e_img;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] relu(input logic [15:0] d);
`ifdef P1W_RELU_EN
      return d[15] ? 16'h0000 : d;
`else
      return d;
`endif
   endfunction

   task automatic chk_outs(input string tag);
      chk({tag, ".wr_en"},   32'(bus.wr_en),   32'(e_we));
      chk({tag, ".wr_addr"}, 32'(bus.wr_addr), 32'(e_addr));
      chk({tag, ".wr_data"}, 32'(bus.wr_data), 32'(e_data));
      chk({tag, ".img_idx"}, 32'(bus.img_idx), 32'(e_img));
      chk({tag, ".done"},    32'(bus.done),    32'(e_done));
   endtask

   // Called at a negedge: drive, check in_ready, cross one rising edge, check outputs.
   task automatic step(input string tag, input logic v, input logic en, input logic [15:0] d);
      logic acc, done_before;
      bus.in_valid = v;
      bus.enable   = en;
      bus.in_data  = d;
      #1;
      chk({tag, ".in_ready"}, 32'(bus.in_ready), 32'(en && !m_done));
      acc         = v && en && !m_done;
      done_before = m_done;
      @(posedge clk);
      if (acc) begin
         e_we   = 1'b1;
         e_addr = 8'(m_cnt % NPIX);
         e_img  = 2'(m_cnt / NPIX);
         e_data = relu(d);
         m_cnt++;
         if (m_cnt == NTOT) m_done = 1'b1;
      end else begin
         e_we = 1'b0;
      end
      e_done = done_before;
      @(negedge clk);
      chk_outs(tag);
   endtask

   task automatic do_reset();
      reset        = 1'b0;
      bus.in_valid = 1'b1;
      bus.enable   = 1'b1;
      bus.in_data  = 16'h7777;
      @(posedge clk);
      @(negedge clk);
      m_cnt = 0; m_done = 1'b0;
      e_we = 1'b0; e_addr = '0; e_data = '0; e_img = '0; e_done = 1'b0;
      chk_outs("rst");
      reset = 1'b1;
   endtask

   initial begin
      logic [15:0] d;
      int          cyc;
      reset        = 1'b0;
      bus.enable   = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
      @(negedge clk);
      do_reset();
      step("idle", 1'b0, 1'b1, 16'h0);

      // gapless frame, value = index, except 0x0005 at the plane-0/1 boundary pixel
      for (int i = 0; i < NTOT; i++) begin
         d = (i == 143) ? 16'h0005 : 16'(i);
         step($sformatf("run%0d", i), 1'b1, 1'b1, d);
      end
      chk("frame.count", 32'(m_cnt), 32'(NTOT));
      for (int i = 0; i < 10; i++)
         step($sformatf("post%0d", i), 1'b1, 1'b1, 16'hABCD);

      // gapped stream with enable toggles: same order, writes only after accepts
      do_reset();
      cyc = 0;
      while (m_cnt < NTOT && cyc < 5000) begin
         step($sformatf("gap%0d", cyc), ($urandom_range(0, 3) != 0),
              ($urandom_range(0, 4) != 0), 16'(m_cnt));
         cyc++;
      end
      chk("gap.complete", 32'(m_cnt), 32'(NTOT));
      step("gap.tail", 1'b1, 1'b1, 16'h1111);

      // reset 70 pixels into plane 1, with a write in flight
      do_reset();
      for (int i = 0; i < NPIX + 70; i++)
         step($sformatf("mid%0d", i), 1'b1, 1'b1, 16'(i));
      chk("mid.img", 32'(bus.img_idx), 32'd1);
      do_reset();
      step("after_rst", 1'b1, 1'b1, 16'h1234);
      chk("after_rst.addr0", 32'(bus.wr_addr), 32'd0);

      // sign boundary through the capture path
      step("neg", 1'b1, 1'b1, 16'hFFF0);
`ifdef P1W_RELU_EN
      chk("neg.relu", 32'(bus.wr_data), 32'h0000);
`else
      chk("neg.raw", 32'(bus.wr_data), 32'hFFF0);
`endif
      step("pos_max", 1'b1, 1'b1, 16'h7FFF);
      step("min", 1'b1, 1'b1, 16'h8000);
      step("hold", 1'b1, 1'b0, 16'h0042);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
